// File: rtl/cdc_cmd_rx.sv
// cdc_cmd_rx -- ASCII register-write command parser behind a USB CDC OUT pipe.
//
// Accepts lines of the form  W|w  HH HH  CR|LF  (address byte, data byte, in
// hex). A well-formed line produces a one-cycle wr_o strobe with addr_o/data_o
// loaded in that same cycle. A malformed line produces exactly one err_o pulse
// when the line's terminator arrives. A partial command that sits idle for
// TIMEOUT cycles is abandoned with an err_o pulse (TIMEOUT = 0 disables this).
//
// Optional feature macro: CDC_CMD_ECHO_EN -- echoes every accepted byte on the
// tx_* port through a one-entry buffer. Without it the tx_* outputs are 0.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   rx_data_i/valid_i    host-to-device byte stream
//   rx_ready_o           byte accepted when rx_valid_i && rx_ready_o
//   wr_o, addr_o, data_o register write strobe and committed address/data
//   err_o                one-cycle malformed-line / timeout pulse
//   tx_data_o/valid_o    echo byte stream, tx_ready_i is its ready
//   dbg_state_o          current parser state, for observation only
//
// Handshake: both byte streams are valid/ready; a transfer happens on a rising
// clk_i edge where valid and ready are both high. valid, once raised by the
// echo side, is held with stable data until that transfer.
module cdc_cmd_rx #(
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic       wr_o,
    output logic [7:0] addr_o,
    output logic [7:0] data_o,
    output logic       err_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE, A_HI, A_LO, D_HI, D_LO, EOL, WRITE, ERR
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic        echo_block;
    logic        accept;
    logic        is_eol, is_w;
    logic        dig_ok;
    logic [3:0]  dig_val;
    logic        in_parse;
    logic        timeout_hit;
    logic [23:0] cnt_q;
    logic        err_d, err_q;
    logic        commit;
    logic [7:0]  pend_addr_q, pend_data_q;
    logic [7:0]  addr_q, data_q;

    // ready_q keeps rx_ready_o low in reset and rises on the first clock after.
    assign rx_ready_o = ready_q && (state_q != WRITE) && !echo_block;
    assign accept     = rx_valid_i && rx_ready_o;
    assign is_eol     = (rx_data_i == 8'h0D) || (rx_data_i == 8'h0A);
    assign is_w       = (rx_data_i == 8'h57) || (rx_data_i == 8'h77);
    assign in_parse   = (state_q == A_HI) || (state_q == A_LO) || (state_q == D_HI) ||
                        (state_q == D_LO) || (state_q == EOL);
    // Fires on the idle cycle that would bring the counter to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 24'd0) && in_parse && !accept &&
                         (cnt_q == TIMEOUT - 24'd1);

    assign wr_o        = (state_q == WRITE);
    assign err_o       = err_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign dbg_state_o = state_q;

    // Hex digit decode: letters A-F / a-f have low nibble 1..6, +9 gives 10..15.
    always_comb begin
        dig_ok  = 1'b0;
        dig_val = 4'h0;
        if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            dig_ok  = 1'b1;
            dig_val = rx_data_i[3:0];
        end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                     (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
            dig_ok  = 1'b1;
            dig_val = rx_data_i[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    // A terminator that shows up where a digit is expected already ends the
    // bad line, so it reports the error at once instead of waiting in ERR for
    // another terminator (which would swallow the following line).
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_w)        state_d = A_HI;
                    else if (is_eol) state_d = IDLE;
                    else             state_d = ERR;
                end
            end
            A_HI, A_LO, D_HI, D_LO: begin
                if (accept) begin
                    if (dig_ok) begin
                        case (state_q)
                            A_HI:    state_d = A_LO;
                            A_LO:    state_d = D_HI;
                            D_HI:    state_d = D_LO;
                            default: state_d = EOL;
                        endcase
                    end else if (is_eol) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            EOL: begin
                if (accept) begin
                    if (is_eol) begin
                        state_d = WRITE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WRITE: state_d = IDLE;
            ERR: begin
                if (accept && is_eol) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle counter runs only while a command is partially received.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                              cnt_q <= 24'd0;
        else if (!in_parse || accept || timeout_hit) cnt_q <= 24'd0;
        else                                      cnt_q <= cnt_q + 24'd1;
    end

    // Pending nibbles stay private until the terminator commits them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_addr_q <= 8'h00;
            pend_data_q <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept && dig_ok) begin
                case (state_q)
                    A_HI:    pend_addr_q[7:4] <= dig_val;
                    A_LO:    pend_addr_q[3:0] <= dig_val;
                    D_HI:    pend_data_q[7:4] <= dig_val;
                    D_LO:    pend_data_q[3:0] <= dig_val;
                    default: ;
                endcase
            end
            if (commit) begin
                addr_q <= pend_addr_q;
                data_q <= pend_data_q;
            end
        end
    end

`ifdef CDC_CMD_ECHO_EN
    logic       tx_valid_q;
    logic [7:0] tx_data_q;

    // One-entry buffer: rx is stalled while it is full, so nothing is dropped.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= rx_data_i;
        end else if (tx_valid_q && tx_ready_i) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign echo_block = tx_valid_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready_i;
    assign echo_block      = 1'b0;
    assign tx_valid_o      = 1'b0;
    assign tx_data_o       = 8'h00;
`endif

endmodule

// File: doc/cdc_cmd_rx.md
CDC_CMD_RX -- requirements
Module: cdc_cmd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd12_000_000, giving the idle cycles allowed between bytes of a partial command (0 = timeout disabled).
REQ-002 SHALL have port clk_i, input, 1, the single clock for all logic (app clock side of the USB CDC).
REQ-003 SHALL have port rstn_i, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port rx_data_i, input, 8, a host-to-device byte (driven from the CDC OUT data).
REQ-005 SHALL have port rx_valid_i, input, 1, which qualifies rx_data_i.
REQ-006 SHALL have port rx_ready_o, output, 1; a byte is accepted in any cycle where rx_valid_i && rx_ready_o.
REQ-007 SHALL have port wr_o, output, 1, a one-cycle register-write strobe.
REQ-008 SHALL have port addr_o, output, 8, the write address, valid and held from wr_o until the next wr_o.
REQ-009 SHALL have port data_o, output, 8, the write data, held in the same way as addr_o.
REQ-010 SHALL have port err_o, output, 1, a one-cycle malformed-command or timeout pulse.
REQ-011 SHALL have port tx_data_o, output, 8, the echo byte.
REQ-012 SHALL have port tx_valid_o, output, 1, the echo valid.
REQ-013 SHALL have port tx_ready_i, input, 1, the echo ready (device-to-host).

Function
REQ-014 SHALL parse the command grammar: 'W'|'w', then four hex digits (addr hi, addr lo, data hi, data lo), then a terminator CR (0x0D) or LF (0x0A).
REQ-015 SHALL accept hex digits '0'-'9', 'A'-'F' and 'a'-'f', mapped to 4-bit values; any other byte is an invalid digit.
REQ-016 SHALL use the states IDLE, A_HI, A_LO, D_HI, D_LO, EOL, WRITE and ERR.
REQ-017 In IDLE: 'W'/'w' -> A_HI; CR/LF -> stay in IDLE (empty line, no error); any other byte -> ERR.
REQ-018 A_HI -> A_LO -> D_HI -> D_LO -> EOL SHALL advance on each accepted valid digit, shifting it into the pending addr/data nibble; an invalid digit -> ERR.
REQ-019 In EOL: CR/LF -> WRITE; any other byte -> ERR.
REQ-020 WRITE SHALL last exactly one cycle: wr_o=1, addr_o/data_o updated in that same cycle, rx_ready_o=0, next state IDLE.
REQ-021 Latency SHALL be: terminator accepted at edge N -> wr_o high during cycle N+1 -> rx_ready_o high again in cycle N+2.
REQ-022 ERR SHALL discard bytes until a CR/LF is accepted, then pulse err_o for one cycle and go to IDLE; err_o SHALL pulse once per bad line.
REQ-023 Timeout: in A_HI..EOL, a 24-bit counter SHALL increment each cycle with no accepted byte and clear on every accepted byte.
REQ-024 When the counter reaches TIMEOUT (TIMEOUT != 0), the block SHALL pulse err_o for one cycle, return to IDLE, clear the counter, and leave addr_o/data_o unchanged.
REQ-025 The timeout counter SHALL be held at 0 in IDLE, ERR and WRITE.
REQ-026 Apart from REQ-020, rx_ready_o SHALL be 1 in every state, subject to REQ-029.
REQ-027 A pending (uncommitted) address SHALL never appear on addr_o before wr_o.

Reset
REQ-028 On rstn_i low, asynchronously: state=IDLE, rx_ready_o=0, wr_o=0, err_o=0, addr_o=0, data_o=0, tx_valid_o=0, tx_data_o=0, timeout counter=0, partial nibbles discarded; rx_ready_o=1 from the first clock after release.

Configuration
REQ-029 With CDC_CMD_ECHO_EN defined:
- each accepted byte SHALL be loaded into tx_data_o with tx_valid_o=1 on the following cycle;
- tx_valid_o SHALL be held until tx_valid_o && tx_ready_i;
- rx_ready_o SHALL be 0 while tx_valid_o=1 (a one-entry echo buffer that never drops or reorders bytes).
Without CDC_CMD_ECHO_EN: tx_valid_o and tx_data_o SHALL be tied to 0, tx_ready_i ignored, and rx_ready_o unaffected.

Verification
REQ-030 Send "W1A5F\r" back-to-back -> one wr_o pulse with addr_o=0x1A, data_o=0x5F, one cycle after '\r' is accepted; err_o stays 0.
REQ-031 Send "wff00\n" then "W0102\r" -> two wr_o pulses, (0xFF,0x00) then (0x01,0x02); lowercase is accepted.
REQ-032 Send "W1G23\r" -> no wr_o, exactly one err_o pulse after '\r'; addr_o/data_o keep their previous values; the next "W0000\r" writes (0x00,0x00).
REQ-033 With TIMEOUT=100, send "W12" then idle 100 cycles -> err_o pulses once and the state returns to IDLE; then "W3456\r" -> wr_o with (0x34,0x56).
REQ-034 Assert rstn_i mid-command after "W12" -> all outputs are 0; "34\r" alone then gives an err_o pulse and no wr_o.
REQ-035 With CDC_CMD_ECHO_EN and tx_ready_i held at 0, send "W" -> tx_valid_o=1 with tx_data_o=0x57 and rx_ready_o=0; raise tx_ready_i for one cycle -> tx_valid_o drops and rx_ready_o returns to 1.
